// File: rtl/zoom_frame_reader.sv
// Zoom frame reader: walks the output frame in raster order, fetches source pixels and streams them out.
// Optional macro ZOOM_READER_ROUND_EN selects round-half-up instead of truncation for the BA average.
module zoom_frame_reader #(
    parameter int SRC_W  = 160,
    parameter int SRC_H  = 120,
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [1:0]        ALGORITHM,
    input  logic [1:0]        SHIFT_FACTOR,
    input  logic [10:0]       IMG_WIDTH_OUT,
    input  logic [9:0]        IMG_HEIGHT_OUT,
    output logic              MEM_RD,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic [DATA_W-1:0] MEM_RDATA,
    output logic [DATA_W-1:0] PIX_DATA,
    output logic              PIX_VALID,
    input  logic              PIX_READY,
    output logic              PIX_EOL,
    output logic              PIX_EOF,
    output logic              BUSY,
    output logic              DONE
);
    localparam int CW    = 15;
    localparam int AW2   = ADDR_W + 2;
    localparam int SUM_W = DATA_W + 2;

    // Tap accumulation happens in WAIT, so a BA pixel costs 4x(FETCH,WAIT)+OUT.
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, OUT, FIN} state_t;

    state_t            state_q, state_d;
    logic [1:0]        alg_q, alg_d;
    logic [1:0]        s_q, s_d;
    logic [10:0]       w_q, w_d;
    logic [9:0]        h_q, h_d;
    logic [10:0]       x_q, x_d;
    logic [9:0]        y_q, y_d;
    logic [1:0]        tap_q, tap_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [DATA_W-1:0] pix_q, pix_d;
    logic              done_q;

    logic              multi;
    logic [CW-1:0]     sx_raw, sy_raw, sx_c, sy_c;
    logic [AW2-1:0]    addr_full;
    logic [1:0]        addr_unused;
    logic [SUM_W-1:0]  acc_sum, rnd_sum;
    logic              last_x, last_y;

    assign multi  = (alg_q == 2'b11) && (s_q != 2'd0);
    assign last_x = (x_q == w_q - 11'd1);
    assign last_y = (y_q == h_q - 10'd1);

    // NN/PR replicate (shift right); DC/BA decimate (shift left), BA adding the tap offset.
    always_comb begin
        if (alg_q[1]) begin
            sx_raw = (CW'(x_q) << s_q) + CW'(multi & tap_q[0]);
            sy_raw = (CW'(y_q) << s_q) + CW'(multi & tap_q[1]);
        end else begin
            sx_raw = CW'(x_q) >> s_q;
            sy_raw = CW'(y_q) >> s_q;
        end
        sx_c = (sx_raw > CW'(SRC_W - 1)) ? CW'(SRC_W - 1) : sx_raw;
        sy_c = (sy_raw > CW'(SRC_H - 1)) ? CW'(SRC_H - 1) : sy_raw;
    end

    assign addr_full   = AW2'(sy_c) * AW2'(SRC_W) + AW2'(sx_c);
    assign addr_unused = addr_full[AW2-1:ADDR_W];

    assign acc_sum = ((tap_q == 2'd0) ? '0 : sum_q) + SUM_W'(MEM_RDATA);
`ifdef ZOOM_READER_ROUND_EN
    assign rnd_sum = acc_sum + SUM_W'(2);
`else
    assign rnd_sum = acc_sum;
`endif

    always_comb begin
        state_d = state_q;
        alg_d   = alg_q;
        s_d     = s_q;
        w_d     = w_q;
        h_d     = h_q;
        x_d     = x_q;
        y_d     = y_q;
        tap_d   = tap_q;
        sum_d   = sum_q;
        pix_d   = pix_q;
        case (state_q)
            IDLE: begin
                if (START) begin
                    alg_d   = ALGORITHM;
                    s_d     = SHIFT_FACTOR;
                    w_d     = IMG_WIDTH_OUT;
                    h_d     = IMG_HEIGHT_OUT;
                    x_d     = '0;
                    y_d     = '0;
                    tap_d   = '0;
                    sum_d   = '0;
                    state_d = (IMG_WIDTH_OUT == '0 || IMG_HEIGHT_OUT == '0) ? FIN : FETCH;
                end
            end
            FETCH: state_d = WAIT;
            WAIT: begin
                sum_d = acc_sum;
                if (multi && tap_q != 2'd3) begin
                    tap_d   = tap_q + 2'd1;
                    state_d = FETCH;
                end else begin
                    pix_d   = multi ? DATA_W'(rnd_sum >> 2) : MEM_RDATA;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (PIX_READY) begin
                    tap_d = '0;
                    if (last_x) begin
                        x_d = '0;
                        if (last_y) begin
                            state_d = FIN;
                        end else begin
                            y_d     = y_q + 10'd1;
                            state_d = FETCH;
                        end
                    end else begin
                        x_d     = x_q + 11'd1;
                        state_d = FETCH;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            alg_q   <= '0;
            s_q     <= '0;
            w_q     <= '0;
            h_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            tap_q   <= '0;
            sum_q   <= '0;
            pix_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            alg_q   <= alg_d;
            s_q     <= s_d;
            w_q     <= w_d;
            h_q     <= h_d;
            x_q     <= x_d;
            y_q     <= y_d;
            tap_q   <= tap_d;
            sum_q   <= sum_d;
            pix_q   <= pix_d;
            done_q  <= (state_q == FIN);
        end
    end

    assign MEM_RD    = (state_q == FETCH);
    assign MEM_ADDR  = MEM_RD ? addr_full[ADDR_W-1:0] : '0;
    assign PIX_VALID = (state_q == OUT);
    assign PIX_DATA  = PIX_VALID ? pix_q : '0;
    assign PIX_EOL   = PIX_VALID & last_x;
    assign PIX_EOF   = PIX_VALID & last_x & last_y;
    assign BUSY      = (state_q == FETCH) || (state_q == WAIT) || (state_q == OUT);
    assign DONE      = done_q;
endmodule

// File: tb/tb_zoom_frame_reader.sv
// Directed bench for zoom_frame_reader: RAM model, expected-pixel queue, per-cycle monitor.
module tb_zoom_frame_reader;
    logic        CLK = 1'b0;
    logic        RESET;
    logic        START = 1'b0;
    logic [1:0]  ALGORITHM = '0;
    logic [1:0]  SHIFT_FACTOR = '0;
    logic [10:0] IMG_WIDTH_OUT = '0;
    logic [9:0]  IMG_HEIGHT_OUT = '0;
    logic        MEM_RD;
    logic [14:0] MEM_ADDR;
    logic [7:0]  MEM_RDATA;
    logic [7:0]  PIX_DATA;
    logic        PIX_VALID;
    logic        PIX_READY = 1'b1;
    logic        PIX_EOL, PIX_EOF, BUSY, DONE;

`ifdef ZOOM_READER_ROUND_EN
    localparam int BA_EXP = 26;
`else
    localparam int BA_EXP = 25;
`endif

    zoom_frame_reader dut (
        .CLK(CLK), .RESET(RESET), .START(START), .ALGORITHM(ALGORITHM),
        .SHIFT_FACTOR(SHIFT_FACTOR), .IMG_WIDTH_OUT(IMG_WIDTH_OUT),
        .IMG_HEIGHT_OUT(IMG_HEIGHT_OUT), .MEM_RD(MEM_RD), .MEM_ADDR(MEM_ADDR),
        .MEM_RDATA(MEM_RDATA), .PIX_DATA(PIX_DATA), .PIX_VALID(PIX_VALID),
        .PIX_READY(PIX_READY), .PIX_EOL(PIX_EOL), .PIX_EOF(PIX_EOF),
        .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    logic [7:0] ram [0:19199];
    always @(posedge CLK) if (MEM_RD) MEM_RDATA <= ram[MEM_ADDR];

    typedef struct {
        logic [7:0] data;
        logic       eol;
        logic       eof;
        int         addr;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0, errors = 0;
    int acc_idx = 0, rd_frame = 0, rds_since = 0, eol_cnt = 0, eof_cnt = 0, done_cnt = 0, last_rd = 0;
    logic [7:0] cap_data [0:8191];
    int         cap_addr [0:8191];
    int         cap_rds  [0:8191];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
            $error("check %s", tag);
        end
    endtask

    function automatic int src_addr(input logic [1:0] alg, input int s, input int x, input int y, input int tap);
        int sx, sy;
        if (alg[1]) begin
            sx = (x << s) + (tap % 2);
            sy = (y << s) + (tap / 2);
        end else begin
            sx = x >> s;
            sy = y >> s;
        end
        if (sx > 159) sx = 159;
        if (sy > 119) sy = 119;
        return sy * 160 + sx;
    endfunction

    task automatic push_frame(input logic [1:0] alg, input int s, input int w, input int h);
        exp_t e;
        int sum;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                if (alg == 2'b11 && s != 0) begin
                    sum = 0;
                    for (int t = 0; t < 4; t++) sum += int'(ram[src_addr(alg, s, x, y, t)]);
`ifdef ZOOM_READER_ROUND_EN
                    sum += 2;
`endif
                    e.data = 8'(sum / 4);
                    e.addr = src_addr(alg, s, x, y, 3);
                end else begin
                    e.addr = src_addr(alg, s, x, y, 0);
                    e.data = ram[e.addr];
                end
                e.eol = (x == w - 1);
                e.eof = (x == w - 1) && (y == h - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    // Runs at the falling edge, between stimulus updates.
    task automatic monitor();
        exp_t e;
        if (!RESET) return;
        if (START && !BUSY) begin
            acc_idx = 0; rd_frame = 0; rds_since = 0;
            eol_cnt = 0; eof_cnt = 0; done_cnt = 0;
        end
        if (MEM_RD) begin
            chk("addr_range", 32'(MEM_ADDR < 15'd19200), 1);
            rd_frame++;
            rds_since++;
            last_rd = int'(MEM_ADDR);
        end
        if (PIX_VALID && PIX_READY) begin
            chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("pix_data", PIX_DATA, e.data);
                chk("pix_eol", PIX_EOL, e.eol);
                chk("pix_eof", PIX_EOF, e.eof);
                chk("pix_addr", last_rd, e.addr);
            end
            $display("pix %0d data=%02h eol=%0d eof=%0d addr=%0d reads=%0d",
                     acc_idx, PIX_DATA, PIX_EOL, PIX_EOF, last_rd, rds_since);
            if (acc_idx < 8192) begin
                cap_data[acc_idx] = PIX_DATA;
                cap_addr[acc_idx] = last_rd;
                cap_rds[acc_idx]  = rds_since;
            end
            rds_since = 0;
            acc_idx++;
            if (PIX_EOL) eol_cnt++;
            if (PIX_EOF) eof_cnt++;
        end else if (!PIX_VALID) begin
            chk("flags_idle", {PIX_EOL, PIX_EOF}, 0);
        end
        if (DONE) done_cnt++;
    endtask

    task automatic tick();
        @(negedge CLK);
        monitor();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_frame(input logic [1:0] alg, input int s, input int w, input int h,
                             input bit poke, output int cyc);
        push_frame(alg, s, w, h);
        ALGORITHM = alg; SHIFT_FACTOR = 2'(s);
        IMG_WIDTH_OUT = 11'(w); IMG_HEIGHT_OUT = 10'(h);
        START = 1'b1;
        tick();
        START = 1'b0;
        ALGORITHM = alg ^ 2'b01; SHIFT_FACTOR = 2'(s + 1);
        IMG_WIDTH_OUT = 11'd3; IMG_HEIGHT_OUT = 10'd1;
        cyc = 1;
        while (done_cnt == 0 && cyc < w * h * 9 + 20) begin
            if (poke && cyc == 10) START = 1'b1;
            tick();
            START = 1'b0;
            cyc++;
        end
        chk("done_seen", done_cnt, 1);
        chk("sb_drained", exp_q.size(), 0);
    endtask

    initial begin
        int cyc, n;
        for (int a = 0; a < 19200; a++) ram[a] = 8'(a);
        RESET = 1'b1;
        #1 RESET = 1'b0;
        tick();
        tick();
        chk("rst_busy", BUSY, 0);
        chk("rst_valid", PIX_VALID, 0);
        chk("rst_rd", MEM_RD, 0);
        chk("rst_done", DONE, 0);
        chk("rst_data", PIX_DATA, 0);
        chk("rst_flags", {PIX_EOL, PIX_EOF}, 0);
        RESET = 1'b1;
        tick();

        // NN s=1 with a START pulse and config churn mid-frame
        run_frame(2'b00, 1, 8, 6, 1'b1, cyc);
        chk("nn_cycles", cyc, 8 * 6 * 3 + 3);
        chk("nn_pix35_data", cap_data[43], 8'h41);
        chk("nn_pix35_addr", cap_addr[43], 321);
        chk("nn_eol_cnt", eol_cnt, 6);
        chk("nn_eof_cnt", eof_cnt, 1);
        chk("nn_accepts", acc_idx, 48);

        // DC s=1 80x60
        run_frame(2'b10, 1, 80, 60, 1'b0, cyc);
        chk("dc_cycles", cyc, 80 * 60 * 3 + 3);
        chk("dc_pix21_addr", cap_addr[82], 324);
        chk("dc_pix21_data", cap_data[82], 8'h44);
        chk("dc_eol_cnt", eol_cnt, 60);
        chk("dc_eof_cnt", eof_cnt, 1);

        // Backpressure on an end-of-row pixel
        ram[0] = 8'hA5;
        push_frame(2'b00, 0, 1, 2);
        ALGORITHM = 2'b00; SHIFT_FACTOR = 2'd0;
        IMG_WIDTH_OUT = 11'd1; IMG_HEIGHT_OUT = 10'd2;
        PIX_READY = 1'b0;
        START = 1'b1;
        tick();
        START = 1'b0;
        chk("bp_busy", BUSY, 1);
        n = 0;
        while (!PIX_VALID && n < 10) begin tick(); n++; end
        chk("bp_valid_reached", PIX_VALID, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_valid", PIX_VALID, 1);
            chk("bp_hold_data", PIX_DATA, 8'hA5);
            chk("bp_hold_eol", PIX_EOL, 1);
            chk("bp_hold_eof", PIX_EOF, 0);
            chk("bp_hold_rd", MEM_RD, 0);
        end
        chk("bp_rd_count", rd_frame, 1);
        PIX_READY = 1'b1;
        tick();
        chk("bp_accept", acc_idx, 1);
        n = 0;
        while (done_cnt == 0 && n < 50) begin tick(); n++; end
        chk("bp_done", done_cnt, 1);
        chk("bp_drained", exp_q.size(), 0);

        // Zero width: DONE two cycles after START, no reads
        ALGORITHM = 2'b00; IMG_WIDTH_OUT = 11'd0; IMG_HEIGHT_OUT = 10'd3;
        START = 1'b1;
        tick();
        START = 1'b0;
        chk("zw_done_early", DONE, 0);
        tick();
        chk("zw_done", DONE, 1);
        tick();
        chk("zw_done_pulse", DONE, 0);
        chk("zw_reads", rd_frame, 0);
        run_frame(2'b00, 0, 5, 0, 1'b0, cyc);
        chk("zh_cycles", cyc, 3);
        chk("zh_reads", rd_frame, 0);

        // BA s=1 over a known 2x2 block, then BA s=0 single read
        ram[0] = 8'd10; ram[1] = 8'd20; ram[160] = 8'd30; ram[161] = 8'd42;
        run_frame(2'b11, 1, 2, 2, 1'b0, cyc);
        chk("ba_pix00", cap_data[0], BA_EXP);
        chk("ba_reads", cap_rds[0], 4);
        chk("ba_cycles", cyc, 4 * 9 + 3);
        run_frame(2'b11, 0, 2, 2, 1'b0, cyc);
        chk("ba0_pix00", cap_data[0], 10);
        chk("ba0_reads", cap_rds[0], 1);
        chk("ba0_cycles", cyc, 4 * 3 + 3);

        // Reset mid-frame around pixel 100
        push_frame(2'b00, 0, 20, 10);
        ALGORITHM = 2'b00; SHIFT_FACTOR = 2'd0;
        IMG_WIDTH_OUT = 11'd20; IMG_HEIGHT_OUT = 10'd10;
        START = 1'b1;
        tick();
        START = 1'b0;
        n = 0;
        while (!(acc_idx >= 100 && PIX_VALID) && n < 2000) begin tick(); n++; end
        chk("rst_mid_reached", 32'(acc_idx >= 100 && PIX_VALID), 1);
        RESET = 1'b0;
        #1;
        chk("rst_mid_busy", BUSY, 0);
        chk("rst_mid_valid", PIX_VALID, 0);
        chk("rst_mid_rd", MEM_RD, 0);
        exp_q.delete();
        tick();
        tick();
        RESET = 1'b1;
        tick();
        run_frame(2'b00, 0, 4, 2, 1'b0, cyc);
        chk("restart_addr", cap_addr[0], 0);
        chk("restart_data", cap_data[0], 10);
        chk("restart_cycles", cyc, 4 * 2 * 3 + 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
